// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for the mesh injection arbiter.
// The helper scans a fixed 16-entry request vector; narrower users zero-pad it.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  // First set request strictly after 'last', wrapping; zero padding above the
  // real requester count makes the wrap behave as modulo NUM_REQ.
  function automatic logic [MAX_IDX_W-1:0] rr_next(
    input logic [MAX_REQ-1:0]   req_vec,
    input logic [MAX_IDX_W-1:0] last
  );
    logic [MAX_IDX_W-1:0] idx_v;
    logic [MAX_IDX_W-1:0] cand_v;
    logic                 hit_v;
    idx_v = last;
    hit_v = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      cand_v = last + MAX_IDX_W'(i);
      if (!hit_v && req_vec[cand_v]) begin
        idx_v = cand_v;
        hit_v = 1'b1;
      end
    end
    return idx_v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: lowest requester index after 'last',
// modulo NUM_REQ, whose request is high.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  logic [MAX_REQ-1:0] req_pad_s;

  assign req_pad_s = MAX_REQ'(req);
  assign idx       = $clog2(NUM_REQ)'(rr_next(req_pad_s, MAX_IDX_W'(last)));
  assign found     = |req;

endmodule

// File: rtl/axis_noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter feeding one mesh injection port through a
// single output register; a grant is held until the grantee's tlast is accepted.
module axis_noc_inject_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           s_axis_tvalid,
  output logic [NUM_REQ-1:0]           s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]       s_axis_tdata [NUM_REQ],
  input  logic [NUM_REQ-1:0]           s_axis_tlast,
  input  logic [TDEST_WIDTH-1:0]       s_axis_tdest [NUM_REQ],
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [TDEST_WIDTH-1:0]       m_axis_tdest,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         pkt_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_r;
  arb_state_e             state_nxt_s;
  logic [IDX_W-1:0]       last_grant_r;
  logic [IDX_W-1:0]       last_grant_nxt_s;
  logic [IDX_W-1:0]       grant_id_r;
  logic [IDX_W-1:0]       grant_id_nxt_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [IDX_W-1:0]       sel_s;
  logic                   pick_found_s;
  logic                   sel_ok_s;
  logic                   load_s;
  logic                   accept_s;
  logic                   cnt_inc_s;
  logic                   ovalid_r;
  logic [TDATA_WIDTH-1:0] odata_r;
  logic                   olast_r;
  logic [TDEST_WIDTH-1:0] odest_r;
  logic [CNT_WIDTH-1:0]   pkt_count_r;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (s_axis_tvalid),
    .last  (last_grant_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // The output register can take a new beat when empty or being drained.
  assign load_s = !ovalid_r || m_axis_tready;

  // Select the requester allowed to transfer this cycle and drive its ready.
  always_comb begin
    sel_s         = pick_idx_s;
    sel_ok_s      = pick_found_s;
    s_axis_tready = '0;
    if (state_r == LOCKED) begin
      sel_s    = grant_id_r;
      sel_ok_s = 1'b1;
    end else begin
      sel_s    = pick_idx_s;
      sel_ok_s = pick_found_s;
    end
    // Ready is forced low while reset is asserted, even though load is high then.
    if (sel_ok_s && load_s && rst_n) begin
      s_axis_tready[sel_s] = 1'b1;
    end else begin
      s_axis_tready = '0;
    end
  end

  assign accept_s = sel_ok_s && load_s && s_axis_tvalid[sel_s];

  // Next-state, round-robin pointer and grant tracking.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    grant_id_nxt_s   = grant_id_r;
    cnt_inc_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          grant_id_nxt_s = sel_s;
          if (s_axis_tlast[sel_s]) begin
            last_grant_nxt_s = sel_s;
            cnt_inc_s        = 1'b1;
          end else begin
            state_nxt_s = LOCKED;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && s_axis_tlast[sel_s]) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = grant_id_r;
          cnt_inc_s        = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbitration state registers; the pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      grant_id_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      grant_id_r   <= grant_id_nxt_s;
    end
  end

  // Output register stage toward the mesh; content holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_r <= 1'b0;
      odata_r  <= '0;
      olast_r  <= 1'b0;
      odest_r  <= '0;
    end else if (load_s) begin
      ovalid_r <= accept_s;
      if (accept_s) begin
        odata_r <= s_axis_tdata[sel_s];
        olast_r <= s_axis_tlast[sel_s];
        odest_r <= s_axis_tdest[sel_s];
      end
    end
  end

  // Completed-packet counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_r <= '0;
    end else if (cnt_inc_s) begin
      pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);
    end
  end

  assign m_axis_tvalid = ovalid_r;
  assign m_axis_tdata  = odata_r;
  assign m_axis_tlast  = olast_r;
  assign m_axis_tdest  = odest_r;
  assign grant_id      = grant_id_r;
  assign busy          = (state_r == LOCKED);
  assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_axis_noc_inject_arbiter.sv
// Directed bench for axis_noc_inject_arbiter: per-requester beat sources, a
// transaction-level arbitration model checked every cycle, and literal log checks.
module tb_axis_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] s_tdata [N];
  logic [N-1:0]  s_tlast;
  logic [TW-1:0] s_tdest [N];
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [TW-1:0] m_tdest;
  logic [1:0]    grant_id;
  logic          busy;
  logic [CW-1:0] pkt_count;

  axis_noc_inject_arbiter #(
    .NUM_REQ(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tdest(m_tdest),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  beat_t         src [N][16];
  int            head [N];
  int            len [N];
  int            gapc [N];
  logic [N-1:0]  acc_seen;
  int            cyc, stall_start, stall_len;

  int            m_owner, m_rr;
  logic [1:0]    m_gid;
  logic [CW-1:0] m_cnt;
  logic          m_ov, m_ol;
  logic [DW-1:0] m_od;
  logic [TW-1:0] m_odst;

  logic [DW-1:0] log_d[$];
  logic [TW-1:0] log_t[$];
  logic [DW-1:0] exp_d[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat dest is the low nibble of its data, so the log can check both.
  task automatic add_beat(input int r, input logic [DW-1:0] d, input logic l, input int g);
    src[r][len[r]] = '{d, l, g};
    len[r]++;
  endtask

  task automatic clear_sources();
    for (int r = 0; r < N; r++) begin
      head[r] = 0;
      len[r]  = 0;
      gapc[r] = 0;
    end
    acc_seen = '0;
  endtask

  task automatic start_sources();
    for (int r = 0; r < N; r++) gapc[r] = (len[r] > 0) ? src[r][0].gap : 0;
    cyc = 0;
  endtask

  task automatic drive_step();
    for (int r = 0; r < N; r++) begin
      if (acc_seen[r]) begin
        head[r]++;
        gapc[r] = (head[r] < len[r]) ? src[r][head[r]].gap : 0;
      end
      if (head[r] < len[r] && gapc[r] == 0) begin
        s_tvalid[r] = 1'b1;
        s_tdata[r]  = src[r][head[r]].data;
        s_tdest[r]  = src[r][head[r]].data[TW-1:0];
        s_tlast[r]  = src[r][head[r]].last;
      end else begin
        if (head[r] < len[r] && gapc[r] > 0) gapc[r]--;
        s_tvalid[r] = 1'b0;
        s_tdata[r]  = '0;
        s_tdest[r]  = '0;
        s_tlast[r]  = 1'b0;
      end
    end
    acc_seen = '0;
    m_tready = !(cyc >= stall_start && cyc < stall_start + stall_len);
    cyc++;
  endtask

  // Arbitration rules applied directly: who may transfer, what lands in the output slot.
  task automatic model_step();
    int           cand;
    logic         ld;
    logic         acc;
    logic [N-1:0] exp_rdy;
    acc_seen = s_tvalid & s_tready;
    if (!rst_n) begin
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdest", m_tdest, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_grant_id", grant_id, 0);
      m_owner = -1; m_rr = N - 1; m_gid = '0; m_cnt = '0;
      m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_odst = '0;
      acc_seen = '0;
    end else begin
      check("m_tvalid", m_tvalid, m_ov);
      check("m_tdata", m_tdata, m_od);
      check("m_tlast", m_tlast, m_ol);
      check("m_tdest", m_tdest, m_odst);
      check("busy", busy, m_owner >= 0);
      check("grant_id", grant_id, m_gid);
      check("pkt_count", pkt_count, m_cnt);
      if (m_tvalid && m_tready) begin
        log_d.push_back(m_tdata);
        log_t.push_back(m_tdest);
      end
      ld   = !m_ov || m_tready;
      cand = m_owner;
      if (cand < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (cand < 0 && s_tvalid[(m_rr + k) % N]) cand = (m_rr + k) % N;
        end
      end
      exp_rdy = '0;
      acc     = 1'b0;
      if (cand >= 0 && ld) begin
        exp_rdy[cand] = 1'b1;
        acc = s_tvalid[cand];
      end
      check("s_tready", s_tready, exp_rdy);
      if (ld) m_ov = acc;
      if (acc) begin
        m_od   = s_tdata[cand];
        m_ol   = s_tlast[cand];
        m_odst = s_tdest[cand];
        m_gid  = 2'(cand);
        if (s_tlast[cand]) begin
          m_owner = -1;
          m_rr    = cand;
          m_cnt   = m_cnt + 16'd1;
        end else begin
          m_owner = cand;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    stall_start = 0;
    stall_len   = 0;
    cyc         = 0;
    drive_step();
    tick();
    tick();
    rst_n = 1'b1;
    log_d.delete();
    log_t.delete();
  endtask

  task automatic run_until_drained();
    logic done;
    done = 1'b0;
    drive_step();
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = !m_ov && (cyc > stall_start + stall_len);
      for (int r = 0; r < N; r++) if (head[r] < len[r]) done = 1'b0;
    end
    check("drain_timeout", done, 1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_log_len"}, log_d.size(), exp_d.size());
    for (int i = 0; i < log_d.size() && i < exp_d.size(); i++) begin
      check({tag, "_log_data"}, log_d[i], exp_d[i]);
      check({tag, "_log_dest"}, log_t[i], exp_d[i][TW-1:0]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int r = 0; r < N; r++) begin
      s_tdata[r] = '0;
      s_tdest[r] = '0;
    end

    // Single one-beat packet from requester 1.
    do_reset();
    add_beat(1, 32'h1, 1'b1, 0);
    start_sources();
    run_until_drained();
    exp_d = '{32'h1};
    compare_log("single");
    check("single_pkt_count", pkt_count, 1);
    check("single_grant_id", grant_id, 1);

    // Four-beat packet from requester 0 is not interleaved with requester 2.
    do_reset();
    for (int i = 0; i < 4; i++) add_beat(0, 32'hA0 + i, (i == 3), 0);
    add_beat(2, 32'hC2, 1'b1, 0);
    start_sources();
    run_until_drained();
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hC2};
    compare_log("atomic");
    check("atomic_pkt_count", pkt_count, 2);
    check("atomic_grant_id", grant_id, 2);

    // All four requesters streaming single-beat packets rotate 0,1,2,3.
    do_reset();
    for (int k = 0; k < 2; k++) for (int r = 0; r < N; r++) add_beat(r, 32'h10 * r + k, 1'b1, 0);
    start_sources();
    run_until_drained();
    exp_d = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h01, 32'h11, 32'h21, 32'h31};
    compare_log("fair");
    check("fair_pkt_count", pkt_count, 8);
    check("fair_grant_id", grant_id, 3);

    // Five-cycle mesh stall in the middle of a packet.
    do_reset();
    for (int i = 0; i < 4; i++) add_beat(1, 32'hB0 + i, (i == 3), 0);
    stall_start = 2;
    stall_len   = 5;
    start_sources();
    run_until_drained();
    exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    compare_log("stall");
    check("stall_pkt_count", pkt_count, 1);

    // Grantee drops valid for three cycles; requester 0 waits for the lock.
    do_reset();
    add_beat(3, 32'hD0, 1'b0, 0);
    add_beat(3, 32'hD1, 1'b1, 3);
    add_beat(0, 32'hE0, 1'b1, 1);
    start_sources();
    run_until_drained();
    exp_d = '{32'hD0, 32'hD1, 32'hE0};
    compare_log("gap");
    check("gap_pkt_count", pkt_count, 2);
    check("gap_grant_id", grant_id, 0);

    // Reset while locked abandons the packet; requester 0 wins first afterwards.
    do_reset();
    for (int i = 0; i < 4; i++) add_beat(2, 32'hF0 + i, (i == 3), 0);
    start_sources();
    drive_step();
    tick();
    tick();
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    clear_sources();
    drive_step();
    tick();
    tick();
    rst_n = 1'b1;
    log_d.delete();
    log_t.delete();
    add_beat(0, 32'h60, 1'b1, 0);
    add_beat(1, 32'h71, 1'b1, 0);
    start_sources();
    run_until_drained();
    exp_d = '{32'h60, 32'h71};
    compare_log("midrst");
    check("midrst_pkt_count", pkt_count, 2);
    check("midrst_grant_id", grant_id, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
